// File: rtl/imm_gen_pipe_if.sv
// Decode-stage handshake bundle: instruction in, decoded immediate out.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;

  // Upstream/downstream side: drives instructions, consumes results.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_pc
  );

  // Immediate generator side.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_pc
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV64/RV32 immediate generator: one registered stage plus a
// one-entry skid register so the input side never stalls a full-rate stream.
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BRANCH_HALF = 0,
  parameter int unsigned PC_EN       = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t            dec;
  logic signed [31:0] imm32;
  logic [31:0]       ins;

  entry_t m_q, m_d;
  entry_t k_q, k_d;
  logic   m_v_q, m_v_d;
  logic   k_v_q, k_v_d;
  logic   rdy_q;

  logic   accept;
  logic   drain;

  assign ins    = bus.in_instr;
  assign accept = bus.in_valid & rdy_q;
  assign drain  = m_v_q & bus.out_ready;

  // Opcode decode and immediate assembly, sign-extended from bit 31 to XLEN.
  always_comb begin
    dec         = '0;
    imm32       = '0;
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b1;
    case (ins[6:0])
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_IMM_32, OP_JALR, OP_SYSTEM: begin
        dec.fmt     = FMT_I;
        dec.illegal = 1'b0;
        imm32       = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        dec.fmt     = FMT_S;
        dec.illegal = 1'b0;
        imm32       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt     = FMT_B;
        dec.illegal = 1'b0;
        if (BRANCH_HALF != 0)
          imm32 = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
        else
          imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt     = FMT_U;
        dec.illegal = 1'b0;
        imm32       = {ins[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt     = FMT_J;
        dec.illegal = 1'b0;
        if (BRANCH_HALF != 0)
          imm32 = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};
        else
          imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_OP, OP_OP_32: begin
        dec.fmt     = FMT_R;
        dec.illegal = 1'b0;
      end
      default: begin
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm   = XLEN'(imm32);
    dec.instr = ins;
    dec.pc    = (PC_EN != 0) ? bus.in_pc : '0;
  end

  // Main/skid next state; flush wins over every transfer.
  always_comb begin
    m_d   = m_q;
    k_d   = k_q;
    m_v_d = m_v_q;
    k_v_d = k_v_q;
    if (flush) begin
      m_v_d = 1'b0;
      k_v_d = 1'b0;
    end else if (drain && k_v_q) begin
      m_d   = k_q;
      m_v_d = 1'b1;
      k_v_d = accept;
      if (accept) k_d = dec;
    end else if (!m_v_q || drain) begin
      m_v_d = accept;
      if (accept) m_d = dec;
    end else if (accept) begin
      k_d   = dec;
      k_v_d = 1'b1;
    end
  end

  // State registers; ready is a flop tracking the next skid occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q   <= '0;
      k_q   <= '0;
      m_v_q <= 1'b0;
      k_v_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      k_q   <= k_d;
      m_v_q <= m_v_d;
      k_v_q <= k_v_d;
      rdy_q <= ~k_v_d;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = m_v_q;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_fmt     = m_q.fmt;
  assign bus.out_illegal = m_q.illegal;
  assign bus.out_instr   = m_q.instr;
  assign bus.out_pc      = m_q.pc;

endmodule
